control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/control_decode.sv | 97 +++++++++
 rtl/control_unit.sv | 105 ++++++++++
 tb/tb_control_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer state encoding and the
// control word that the sequencer hands to the datapath.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_e;

    typedef struct packed {
        logic pci;
        logic pco;
        logic iri;
        logic mari;
        logic mdri;
        logic mdro;
        logic mem_read;
        logic mem_write;
        logic ryi;
        logic zi;
        logic zlo;
        logic inc_pc;
        logic alu_add;
        logic gra;
        logic grb;
        logic rin;
        logic rout;
        logic baout;
        logic csigno;
        logic instr_done;
        logic illegal;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational Moore decode: (state, opcode) to datapath control word.
// The opcode is only consulted from T3 on, once IR holds the new word.
module control_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_e         state,
    input  logic [OPW-1:0] op,
    output ctrl_t          ctrl
);

    logic is_ld;
    logic is_ldi;
    logic is_st;
    logic is_known;

    assign is_ld    = (op == OPW'(OP_LD));
    assign is_ldi   = (op == OPW'(OP_LDI));
    assign is_st    = (op == OPW'(OP_ST));
    assign is_known = (op == OPW'(OP_NOP)) || (op == OPW'(OP_HALT));

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != HALT);
        case (state)
            T0: begin
                ctrl.pco    = 1'b1;
                ctrl.mari   = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.zi     = 1'b1;
            end
            T1: begin
                ctrl.zlo      = 1'b1;
                ctrl.pci      = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mdri     = 1'b1;
            end
            T2: begin
                ctrl.mdro = 1'b1;
                ctrl.iri  = 1'b1;
            end
            T3: begin
                if (is_ld || is_ldi || is_st) begin
                    ctrl.grb   = 1'b1;
                    ctrl.baout = 1'b1;
                    ctrl.ryi   = 1'b1;
                end else begin
                    ctrl.instr_done = 1'b1;
                    ctrl.illegal    = !is_known;
                end
            end
            T4: begin
                if (is_ld || is_ldi || is_st) begin
                    ctrl.csigno  = 1'b1;
                    ctrl.alu_add = 1'b1;
                    ctrl.zi      = 1'b1;
                end
            end
            T5: begin
                if (is_ldi) begin
                    ctrl.zlo        = 1'b1;
                    ctrl.gra        = 1'b1;
                    ctrl.rin        = 1'b1;
                    ctrl.instr_done = 1'b1;
                end else if (is_ld || is_st) begin
                    ctrl.zlo  = 1'b1;
                    ctrl.mari = 1'b1;
                end
            end
            T6: begin
                // st leaves mem_read low so MDR takes the register bus
                if (is_ld) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.mdri     = 1'b1;
                end else if (is_st) begin
                    ctrl.gra  = 1'b1;
                    ctrl.rout = 1'b1;
                    ctrl.mdri = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    ctrl.mdro       = 1'b1;
                    ctrl.gra        = 1'b1;
                    ctrl.rin        = 1'b1;
                    ctrl.instr_done = 1'b1;
                end else if (is_st) begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired sequencer: state register plus next-state logic; the
// control word itself comes from control_decode.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    output logic        pci,
    output logic        pco,
    output logic        iri,
    output logic        mari,
    output logic        mdri,
    output logic        mdro,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ryi,
    output logic        zi,
    output logic        zlo,
    output logic        inc_pc,
    output logic        alu_add,
    output logic        gra,
    output logic        grb,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        csigno,
    output logic        run,
    output logic        instr_done,
    output logic        illegal
);

    state_e         state_q;
    state_e         state_d;
    logic [OPW-1:0] op;
    logic           unused_ir;
    ctrl_t          ctrl;

    assign op        = ir[31 -: OPW];
    assign unused_ir = ^ir[31-OPW:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST: state_d = T0;
            T0:  state_d = T1;
            T1:  state_d = T2;
            T2:  state_d = T3;
            T3: begin
                if (op == OPW'(OP_LD) || op == OPW'(OP_LDI) ||
                    op == OPW'(OP_ST))
                    state_d = T4;
                else if (op == OPW'(OP_HALT))
                    state_d = HALT;
                else
                    state_d = T0;
            end
            T4:  state_d = T5;
            T5:  state_d = (op == OPW'(OP_LDI)) ? T0 : T6;
            T6:  state_d = T7;
            T7:  state_d = T0;
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear)
            state_q <= RST;
        else
            state_q <= state_d;
    end

    control_decode #(.OPW(OPW)) u_decode (
        .state (state_q),
        .op    (op),
        .ctrl  (ctrl)
    );

    assign pci        = ctrl.pci;
    assign pco        = ctrl.pco;
    assign iri        = ctrl.iri;
    assign mari       = ctrl.mari;
    assign mdri       = ctrl.mdri;
    assign mdro       = ctrl.mdro;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ryi        = ctrl.ryi;
    assign zi         = ctrl.zi;
    assign zlo        = ctrl.zlo;
    assign inc_pc     = ctrl.inc_pc;
    assign alu_add    = ctrl.alu_add;
    assign gra        = ctrl.gra;
    assign grb        = ctrl.grb;
    assign rin        = ctrl.rin;
    assign rout       = ctrl.rout;
    assign baout      = ctrl.baout;
    assign csigno     = ctrl.csigno;
    assign run        = ctrl.run;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: step-by-step expected control words
// for fetch, ld, ldi, st, nop, illegal, halt and clear aborts.
module tb_control_unit;

    typedef logic [21:0] cw_t;

    localparam cw_t PCI   = 22'h1 << 21;
    localparam cw_t PCO   = 22'h1 << 20;
    localparam cw_t IRI   = 22'h1 << 19;
    localparam cw_t MARI  = 22'h1 << 18;
    localparam cw_t MDRI  = 22'h1 << 17;
    localparam cw_t MDRO  = 22'h1 << 16;
    localparam cw_t MRD   = 22'h1 << 15;
    localparam cw_t MWR   = 22'h1 << 14;
    localparam cw_t RYI   = 22'h1 << 13;
    localparam cw_t ZI    = 22'h1 << 12;
    localparam cw_t ZLO   = 22'h1 << 11;
    localparam cw_t INCPC = 22'h1 << 10;
    localparam cw_t ADD   = 22'h1 << 9;
    localparam cw_t GRA   = 22'h1 << 8;
    localparam cw_t GRB   = 22'h1 << 7;
    localparam cw_t RIN   = 22'h1 << 6;
    localparam cw_t ROUT  = 22'h1 << 5;
    localparam cw_t BAOUT = 22'h1 << 4;
    localparam cw_t CSIGN = 22'h1 << 3;
    localparam cw_t DONE  = 22'h1 << 2;
    localparam cw_t ILL   = 22'h1 << 1;
    localparam cw_t RUN   = 22'h1;

    localparam cw_t E_T0 = PCO | MARI | INCPC | ZI | RUN;
    localparam cw_t E_T1 = ZLO | PCI | MRD | MDRI | RUN;
    localparam cw_t E_T2 = MDRO | IRI | RUN;
    localparam cw_t E_T3 = GRB | BAOUT | RYI | RUN;
    localparam cw_t E_T4 = CSIGN | ADD | ZI | RUN;
    localparam cw_t E_T5 = ZLO | MARI | RUN;

    localparam logic [31:0] IR_LD   = 32'h0080_0055;
    localparam logic [31:0] IR_LDI  = 32'h0900_0007;
    localparam logic [31:0] IR_ST   = 32'h1180_0020;
    localparam logic [31:0] IR_ILL  = 32'h1800_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_JUNK = 32'hFFFF_FFFF;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        chk;
        cw_t         exp;
    } vec_t;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic pci, pco, iri, mari, mdri, mdro, mem_read, mem_write;
    logic ryi, zi, zlo, inc_pc, alu_add, gra, grb, rin, rout;
    logic baout, csigno, run, instr_done, illegal;
    cw_t  dut_cw;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    control_unit #(.OPW(5)) dut (
        .clock      (clock),
        .clear      (clear),
        .ir         (ir),
        .pci        (pci),
        .pco        (pco),
        .iri        (iri),
        .mari       (mari),
        .mdri       (mdri),
        .mdro       (mdro),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ryi        (ryi),
        .zi         (zi),
        .zlo        (zlo),
        .inc_pc     (inc_pc),
        .alu_add    (alu_add),
        .gra        (gra),
        .grb        (grb),
        .rin        (rin),
        .rout       (rout),
        .baout      (baout),
        .csigno     (csigno),
        .run        (run),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign dut_cw = {pci, pco, iri, mari, mdri, mdro, mem_read, mem_write,
                     ryi, zi, zlo, inc_pc, alu_add, gra, grb, rin, rout,
                     baout, csigno, instr_done, illegal, run};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic c, input logic [31:0] i,
                       input logic k, input cw_t e);
        vecs.push_back('{clr: c, ir: i, chk: k, exp: e});
    endtask

    task automatic add_fetch();
        add(1'b0, IR_JUNK, 1'b1, E_T0);
        add(1'b0, IR_JUNK, 1'b1, E_T1);
        add(1'b0, 32'h0,   1'b1, E_T2);
    endtask

    task automatic check(input string name, input cw_t exp);
        n_tests++;
        if (dut_cw !== exp || (mem_read && mem_write)) begin
            n_fail++;
            $display("FAIL %s: got %06h want %06h", name, dut_cw, exp);
        end
    endtask

    // Drive at the falling edge, compare mid-cycle, state advances next rise
    task automatic step(input string name, input logic c,
                        input logic [31:0] i, input cw_t e);
        @(negedge clock);
        clear = c;
        ir    = i;
        #1;
        check(name, e);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear   = 1'b1;
        ir      = 32'h0;

        add(1'b1, IR_JUNK, 1'b0, '0);
        add(1'b1, IR_JUNK, 1'b1, RUN);
        add(1'b0, IR_JUNK, 1'b1, RUN);
        add_fetch();
        add(1'b0, IR_LD, 1'b1, E_T3);
        add(1'b0, IR_LD, 1'b1, E_T4);
        add(1'b0, IR_LD, 1'b1, E_T5);
        add(1'b0, IR_LD, 1'b1, MRD | MDRI | RUN);
        add(1'b0, IR_LD, 1'b1, MDRO | GRA | RIN | DONE | RUN);
        add_fetch();
        add(1'b0, IR_LDI, 1'b1, E_T3);
        add(1'b0, IR_LDI, 1'b1, E_T4);
        add(1'b0, IR_LDI, 1'b1, ZLO | GRA | RIN | DONE | RUN);
        add_fetch();
        add(1'b0, IR_ST, 1'b1, E_T3);
        add(1'b0, IR_ST, 1'b1, E_T4);
        add(1'b0, IR_ST, 1'b1, E_T5);
        add(1'b0, IR_ST, 1'b1, GRA | ROUT | MDRI | RUN);
        add(1'b0, IR_ST, 1'b1, MWR | DONE | RUN);
        add_fetch();
        add(1'b0, IR_ILL, 1'b1, ILL | DONE | RUN);
        add_fetch();
        add(1'b0, IR_NOP, 1'b1, DONE | RUN);
        add_fetch();
        add(1'b0, IR_HALT, 1'b1, DONE | RUN);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clock);
            clear = vecs[n].clr;
            ir    = vecs[n].ir;
            #1;
            if (vecs[n].chk)
                check($sformatf("vec%0d", n), vecs[n].exp);
        end

        for (int k = 0; k < 20; k++)
            step($sformatf("halt%0d", k), 1'b0, IR_JUNK, '0);
        step("halt_clr", 1'b1, IR_HALT, '0);
        step("halt_rst", 1'b0, IR_HALT, RUN);

        step("ab_t0", 1'b0, IR_JUNK, E_T0);
        step("ab_t1", 1'b0, IR_JUNK, E_T1);
        step("ab_t2", 1'b0, 32'h0, E_T2);
        step("ab_t3", 1'b0, IR_ST, E_T3);
        step("ab_t4", 1'b0, IR_ST, E_T4);
        step("ab_t5", 1'b0, IR_ST, E_T5);
        step("ab_t6", 1'b1, IR_ST, GRA | ROUT | MDRI | RUN);
        step("ab_rst", 1'b0, IR_ST, RUN);
        step("ab_t0b", 1'b0, IR_JUNK, E_T0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
